// File: rtl/d2l_pkg.sv
// Shared line-to-data definitions: default widths, FSM state encoding and
// DATA_OUT field offsets, used by both the receive and transmit sides.
package d2l_pkg;

   localparam int LEN_W     = 7;
   localparam int PAYLOAD_W = 64;

   // DATA_OUT = {length, zero-extended payload}
   localparam int DOUT_PAYLOAD_LSB = 0;
   localparam int DOUT_LEN_LSB     = PAYLOAD_W;
   localparam int DOUT_W           = LEN_W + PAYLOAD_W;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_PAR  = 3'd3,
      ST_STOP = 3'd4
   } state_e;

endpackage

// File: rtl/l2d_shreg.sv
// Strobed LSB-first capture register with bit counter: the bit strobed while
// the counter reads i lands in data bit i, so a frame needs no realignment.
module l2d_shreg #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             shift,
   input  logic             bit_in,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (shift) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CNT_W'(i)) data_d[i] = bit_in;
         end
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rstn) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign data = data_q;
   assign cnt  = cnt_q;

endmodule

// File: rtl/l2d_rx.sv
// Serial line-to-data frame receiver: start, length, payload, [parity], stop.
// Define L2D_PARITY_EN to add an even-parity bit checked after the payload.
module l2d_rx #(
   parameter int PAYLOAD_W = d2l_pkg::PAYLOAD_W,
   parameter int LEN_W     = d2l_pkg::LEN_W,
   parameter int TIMEOUT   = 255
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       rx_en,
   input  logic                       line_d,
   input  logic                       line_vld,
   output logic                       BUSY,
   output logic                       DONE,
   output logic                       ERR,
   output logic [LEN_W+PAYLOAD_W-1:0] DATA_OUT
);

   import d2l_pkg::*;

   localparam int CNT_W = $clog2(PAYLOAD_W + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   state_e                     state_q, state_d;
   logic [LEN_W-1:0]           len_q, len_d, len_cur;
   logic [TMO_W-1:0]           tmo_q, tmo_d;
   logic                       busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [LEN_W+PAYLOAD_W-1:0] dout_q, dout_d;
   logic                       sr_clr, sr_shift;
   logic [PAYLOAD_W-1:0]       sr_data;
   logic [CNT_W-1:0]           sr_cnt;

   l2d_shreg #(.WIDTH(PAYLOAD_W), .CNT_W(CNT_W)) u_shreg (
      .clk    (clk),
      .rstn   (rstn),
      .clr    (sr_clr),
      .shift  (sr_shift),
      .bit_in (line_d),
      .data   (sr_data),
      .cnt    (sr_cnt)
   );

   // Length as it will read once the bit now on the line is included.
   assign len_cur = {line_d, sr_data[LEN_W-2:0]};

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      tmo_d    = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      dout_d   = dout_q;
      sr_clr   = 1'b0;
      sr_shift = 1'b0;

      if (state_q != ST_IDLE && !line_vld) begin
         if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: if (rx_en && line_vld && !line_d) begin
            state_d = ST_LEN;
            sr_clr  = 1'b1;
         end
         ST_LEN: if (line_vld) begin
            sr_shift = 1'b1;
            if (sr_cnt == CNT_W'(LEN_W - 1)) begin
               sr_clr = 1'b1;
               if (len_cur == '0 || int'(len_cur) > PAYLOAD_W) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  len_d   = len_cur;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: if (line_vld) begin
            sr_shift = 1'b1;
            if (int'(sr_cnt) + 1 == int'(len_q)) begin
`ifdef L2D_PARITY_EN
               state_d = ST_PAR;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef L2D_PARITY_EN
         // Bits above length were cleared, so parity over the register is parity over the payload.
         ST_PAR: if (line_vld) begin
            if (line_d != ^sr_data) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: if (line_vld) begin
            state_d = ST_IDLE;
            if (line_d) begin
               dout_d = {len_q, sr_data};
               done_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign ERR      = err_q;
   assign DATA_OUT = dout_q;

endmodule
